// File: rtl/touch_filter.sv
// Touch-panel coordinate filter: synchronises the pen interrupt, drops the first
// settling sample of each touch and averages 2**N_LOG2 samples per output.
module touch_filter #(
    parameter int N_LOG2    = 2,
    parameter int TIMEOUT   = 50000,
    parameter int PENUP_CYC = 16
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic [11:0] iX_COORD,
    input  logic [11:0] iY_COORD,
    input  logic        iCOORD_VALID,
    input  logic        iADC_PENIRQ_n,
    output logic [11:0] oX_AVG,
    output logic [11:0] oY_AVG,
    output logic        oVALID,
    output logic        oTOUCH
);

    localparam int ACC_W = 12 + N_LOG2;
    localparam int CNT_W = N_LOG2;
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int PU_W  = $clog2(PENUP_CYC + 1);

    typedef enum logic [1:0] {
        IDLE,
        DISCARD,
        ACCUM
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               pen_meta;
    logic               pen;
    logic [PU_W-1:0]    penup_cnt;
    logic [TO_W-1:0]    timeout_cnt;
    logic [ACC_W-1:0]   acc_x;
    logic [ACC_W-1:0]   acc_y;
    logic [CNT_W-1:0]   sample_cnt;
    logic [ACC_W-1:0]   sum_x;
    logic [ACC_W-1:0]   sum_y;
    logic               active;
    logic               penup_exit;
    logic               timeout_exit;
    logic               leave;
    logic               accept;
    logic               complete;

    // Synchroniser resets to pen-up so a reset never looks like a touch.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            pen_meta <= 1'b1;
            pen      <= 1'b1;
        end else begin
            pen_meta <= iADC_PENIRQ_n;
            pen      <= pen_meta;
        end
    end

    // Exits take priority over a coincident strobe, so the strobe is never accepted.
    always_comb begin
        active       = (state != IDLE);
        penup_exit   = active && pen && (penup_cnt == PU_W'(PENUP_CYC - 1));
        timeout_exit = active && (timeout_cnt == TO_W'(TIMEOUT - 1));
        leave        = penup_exit || timeout_exit;
        accept       = active && iCOORD_VALID && !leave;
        sum_x        = acc_x + ACC_W'(iX_COORD);
        sum_y        = acc_y + ACC_W'(iY_COORD);
        complete     = (state == ACCUM) && accept &&
                       (sample_cnt == CNT_W'(2**N_LOG2 - 1));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!pen) state_next = DISCARD;
            DISCARD: begin
                if (leave)       state_next = IDLE;
                else if (accept) state_next = ACCUM;
            end
            ACCUM:   if (leave) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) state <= IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            penup_cnt   <= '0;
            timeout_cnt <= '0;
        end else begin
            if (!active || !pen || leave) penup_cnt <= '0;
            else                          penup_cnt <= penup_cnt + PU_W'(1);

            if (!active || leave || accept) timeout_cnt <= '0;
            else                            timeout_cnt <= timeout_cnt + TO_W'(1);
        end
    end

    // Partial sums are dropped on every exit; a completed block restarts from zero.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            acc_x      <= '0;
            acc_y      <= '0;
            sample_cnt <= '0;
        end else if (!active || leave || complete) begin
            acc_x      <= '0;
            acc_y      <= '0;
            sample_cnt <= '0;
        end else if (accept && state == ACCUM) begin
            acc_x      <= sum_x;
            acc_y      <= sum_y;
            sample_cnt <= sample_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oX_AVG <= '0;
            oY_AVG <= '0;
            oVALID <= 1'b0;
            oTOUCH <= 1'b0;
        end else begin
            oVALID <= complete;
            if (complete) begin
                oX_AVG <= sum_x[ACC_W-1:N_LOG2];
                oY_AVG <= sum_y[ACC_W-1:N_LOG2];
            end
            if (leave)         oTOUCH <= 1'b0;
            else if (complete) oTOUCH <= 1'b1;
        end
    end

endmodule
